// File: rtl/clock_ui_pkg.sv
// Shared definitions for the clock front panel: mode encodings, field selects
// and default timing constants used by the controller and the counter chain.
package clock_ui_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYC = 50000;
   localparam int unsigned DEF_BLINK_CYC    = 12500000;
   localparam int unsigned DEF_TIMEOUT_S    = 30;
   localparam int unsigned MODE_W           = 3;

   typedef enum logic [MODE_W-1:0] {
      ST_RUN      = 3'd0,
      ST_PAUSE    = 3'd1,
      ST_SET_HOUR = 3'd2,
      ST_SET_MIN  = 3'd3,
      ST_SET_SEC  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      FIELD_NONE = 2'd0,
      FIELD_SEC  = 2'd1,
      FIELD_MIN  = 2'd2,
      FIELD_HOUR = 2'd3
   } field_t;

   // Display/counter field edited in a given mode
   function automatic field_t field_of(input state_t s);
      field_t f;
      f = FIELD_NONE;
      case (s)
         ST_SET_HOUR: f = FIELD_HOUR;
         ST_SET_MIN:  f = FIELD_MIN;
         ST_SET_SEC:  f = FIELD_SEC;
         default:     f = FIELD_NONE;
      endcase
      return f;
   endfunction

   // True for any of the three time-setting modes
   function automatic logic is_set(input state_t s);
      return field_of(s) != FIELD_NONE;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-key conditioner: two-flop synchroniser, stability counter and a
// one-cycle press pulse on the accepted 1->0 transition. After reset the key
// must be seen released for a full debounce window before presses are armed,
// so a key held through reset produces no event.
module key_debounce
   import clock_ui_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press,
   output logic level
);

   localparam int unsigned   CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic          armed;
   logic          differ;
   logic [CW-1:0] cnt;

   // Unarmed: wait for a stable release. Armed: wait for a stable change of level.
   assign differ = armed ? (sync2 != level) : sync2;

   // Bring the asynchronous key into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Stability counter, accepted level and press pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b1;
         armed <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (!differ) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (armed) begin
               level <= sync2;
               press <= ~sync2;
            end else begin
               armed <= 1'b1;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller for the digital clock: debounces the mode/inc/run
// keys, runs the RUN/PAUSE/SET_* mode FSM, and drives the counter-chain
// enable, single-cycle increment strobes and per-field blink blanking.
// Optional build macro CLOCK_MODE_CTRL_AUTOREPEAT_EN adds hold-to-repeat on
// the increment key in the SET_* modes.
module clock_mode_ctrl
   import clock_ui_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned BLINK_CYC    = DEF_BLINK_CYC,
   parameter int unsigned TIMEOUT_S    = DEF_TIMEOUT_S
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_1hz,
   input  logic              key_mode_n,
   input  logic              key_inc_n,
   input  logic              key_run_n,
   output logic              run_en,
   output logic              inc_sec,
   output logic              inc_min,
   output logic              inc_hour,
   output logic [MODE_W-1:0] mode,
   output logic              blank_sec,
   output logic              blank_min,
   output logic              blank_hour
);

   localparam int unsigned   TW       = 6;
   localparam int unsigned   BW       = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_S - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYC - 1);

   state_t        state, state_next;
   logic [TW-1:0] tcnt, tcnt_next;
   logic [BW-1:0] blink_cnt, blink_cnt_next;
   logic          blink_phase, blink_phase_next;
   logic          run_en_next, inc_sec_next, inc_min_next, inc_hour_next;
   logic          blank_sec_next, blank_min_next, blank_hour_next;

   logic          mode_press, inc_press, run_press;
   logic          mode_level, inc_level, run_level;
   logic          rep_fire, inc_evt, any_press, timeout_hit;
   logic          unused_levels;
   field_t        cur_field, inc_field;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
      .clk(clk), .rst(rst), .key_n(key_mode_n), .press(mode_press), .level(mode_level)
   );
   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_inc (
      .clk(clk), .rst(rst), .key_n(key_inc_n), .press(inc_press), .level(inc_level)
   );
   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_run (
      .clk(clk), .rst(rst), .key_n(key_run_n), .press(run_press), .level(run_level)
   );

`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
   localparam int unsigned   RW        = $clog2(64 * DEBOUNCE_CYC);
   localparam logic [RW-1:0] REP_FIRST = RW'(64 * DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] REP_NEXT  = RW'(16 * DEBOUNCE_CYC - 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_first;
   logic [RW-1:0] rep_limit;

   assign rep_limit = rep_first ? REP_FIRST : REP_NEXT;
   assign rep_fire  = is_set(state) && !inc_level && (rep_cnt == rep_limit);

   // Hold timer for the increment key; cleared on release or any mode change
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (!is_set(state) || inc_level || (state_next != state)) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (rep_cnt == rep_limit) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else begin
         rep_cnt <= rep_cnt + RW'(1);
      end
   end

   assign unused_levels = ^{mode_level, run_level};
`else
   assign rep_fire      = 1'b0;
   assign unused_levels = ^{mode_level, run_level, inc_level};
`endif

   assign inc_evt     = inc_press | rep_fire;
   assign any_press   = mode_press | inc_press | run_press | rep_fire;
   assign cur_field   = field_of(state);
   assign timeout_hit = is_set(state) && tick_1hz && !any_press && (tcnt == TO_LAST);
   assign mode        = MODE_W'(state);

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         run_en      <= 1'b1;
         inc_sec     <= 1'b0;
         inc_min     <= 1'b0;
         inc_hour    <= 1'b0;
         blank_sec   <= 1'b0;
         blank_min   <= 1'b0;
         blank_hour  <= 1'b0;
         tcnt        <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         state       <= state_next;
         run_en      <= run_en_next;
         inc_sec     <= inc_sec_next;
         inc_min     <= inc_min_next;
         inc_hour    <= inc_hour_next;
         blank_sec   <= blank_sec_next;
         blank_min   <= blank_min_next;
         blank_hour  <= blank_hour_next;
         tcnt        <= tcnt_next;
         blink_cnt   <= blink_cnt_next;
         blink_phase <= blink_phase_next;
      end
   end

   // Next-state, strobe, timeout and blink logic; mode press has priority
   always_comb begin
      state_next       = state;
      inc_field        = FIELD_NONE;
      tcnt_next        = tcnt;
      blink_cnt_next   = blink_cnt + BW'(1);
      blink_phase_next = blink_phase;

      case (state)
         ST_RUN: begin
            if (mode_press)     state_next = ST_SET_HOUR;
            else if (run_press) state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (mode_press)     state_next = ST_SET_HOUR;
            else if (run_press) state_next = ST_RUN;
         end
         ST_SET_HOUR: begin
            if (mode_press)       state_next = ST_SET_MIN;
            else if (timeout_hit) state_next = ST_RUN;
         end
         ST_SET_MIN: begin
            if (mode_press)       state_next = ST_SET_SEC;
            else if (timeout_hit) state_next = ST_RUN;
         end
         ST_SET_SEC: begin
            if (mode_press)       state_next = ST_RUN;
            else if (timeout_hit) state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase

      if (inc_evt && !mode_press) inc_field = cur_field;

      run_en_next     = (state == ST_RUN);
      inc_sec_next    = (inc_field == FIELD_SEC);
      inc_min_next    = (inc_field == FIELD_MIN);
      inc_hour_next   = (inc_field == FIELD_HOUR);
      blank_sec_next  = (cur_field == FIELD_SEC)  && blink_phase;
      blank_min_next  = (cur_field == FIELD_MIN)  && blink_phase;
      blank_hour_next = (cur_field == FIELD_HOUR) && blink_phase;

      if (!is_set(state) || (state_next != state) || any_press) tcnt_next = '0;
      else if (tick_1hz)                                         tcnt_next = tcnt + TW'(1);

      if (is_set(state_next) && (state_next != state)) begin
         blink_cnt_next   = '0;
         blink_phase_next = 1'b0;
      end else if (blink_cnt == BLK_LAST) begin
         blink_cnt_next   = '0;
         blink_phase_next = ~blink_phase;
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with short debounce/blink/timeout values.
module tb_clock_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       key_mode_n;
   logic       key_inc_n;
   logic       key_run_n;
   logic       run_en;
   logic       inc_sec;
   logic       inc_min;
   logic       inc_hour;
   logic [2:0] mode;
   logic       blank_sec;
   logic       blank_min;
   logic       blank_hour;

   int vectors     = 0;
   int miscompares = 0;

   int         cyc_idx, n_sec, n_min, n_hour, n_mode_chg, run_len, max_run;
   int         first_min_idx, blink_last, blink_tog, blink_bad, n_bs, n_bh;
   logic [2:0] prev_mode;
   logic       prev_bmin;

   clock_mode_ctrl #(
      .DEBOUNCE_CYC(4),
      .BLINK_CYC(8),
      .TIMEOUT_S(3)
   ) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_run_n(key_run_n),
      .run_en(run_en), .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
      .mode(mode), .blank_sec(blank_sec), .blank_min(blank_min), .blank_hour(blank_hour)
   );

   always #5 clk = ~clk;

   // Advance one clock and record what the outputs did
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_idx++;
      if (inc_sec)  n_sec++;
      if (inc_min)  n_min++;
      if (inc_hour) n_hour++;
      if (blank_sec)  n_bs++;
      if (blank_hour) n_bh++;
      if (inc_sec || inc_min || inc_hour) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (inc_min && first_min_idx < 0) first_min_idx = cyc_idx;
      if (mode !== prev_mode) begin
         n_mode_chg++;
         prev_mode = mode;
      end
      if (blank_min !== prev_bmin) begin
         if (blink_last >= 0 && (cyc_idx - blink_last) != 8) blink_bad++;
         blink_last = cyc_idx;
         blink_tog++;
         prev_bmin  = blank_min;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) cyc();
   endtask

   task automatic clear_obs();
      cyc_idx = 0; n_sec = 0; n_min = 0; n_hour = 0; n_mode_chg = 0;
      run_len = 0; max_run = 0; first_min_idx = -1;
      blink_last = -1; blink_tog = 0; blink_bad = 0; n_bs = 0; n_bh = 0;
      prev_mode = mode; prev_bmin = blank_min;
   endtask

   // which: 0 = mode, 1 = inc, 2 = run, 3 = mode+inc together
   task automatic press_key(input int which, input int low_cyc);
      if (which == 0 || which == 3) key_mode_n = 1'b0;
      if (which == 1 || which == 3) key_inc_n  = 1'b0;
      if (which == 2)               key_run_n  = 1'b0;
      cycles(low_cyc);
      key_mode_n = 1'b1; key_inc_n = 1'b1; key_run_n = 1'b1;
      cycles(10);
   endtask

   task automatic pulse_tick();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick_1hz = 1'b0;
      key_mode_n = 1'b1; key_inc_n = 1'b1; key_run_n = 1'b1;
      clear_obs();
      cycles(2);
      vectors++;
      if (run_en !== 1'b1) begin miscompares++; $display("FAIL reset_run_en: got %b expected 1", run_en); end
      vectors++;
      if (mode !== 3'd0) begin miscompares++; $display("FAIL reset_mode: got %0d expected 0", mode); end
      vectors++;
      if ({inc_sec, inc_min, inc_hour} !== 3'b000) begin
         miscompares++; $display("FAIL reset_inc: got %b expected 000", {inc_sec, inc_min, inc_hour});
      end
      vectors++;
      if ({blank_sec, blank_min, blank_hour} !== 3'b000) begin
         miscompares++; $display("FAIL reset_blank: got %b expected 000", {blank_sec, blank_min, blank_hour});
      end
      rst = 1'b0;
      cycles(10);
   endtask

   task automatic test_debounce();
      clear_obs();
      key_mode_n = 1'b0;
      cycles(3);
      key_mode_n = 1'b1;
      cycles(12);
      vectors++;
      if (n_mode_chg !== 0 || mode !== 3'd0) begin
         miscompares++; $display("FAIL short_glitch: changes %0d mode %0d expected 0 changes mode 0", n_mode_chg, mode);
      end
      clear_obs();
      key_mode_n = 1'b0;
      cycles(6);
      vectors++;
      if (mode !== 3'd0) begin miscompares++; $display("FAIL press_early: mode %0d expected 0", mode); end
      cycles(1);
      vectors++;
      if (mode !== 3'd2 || run_en !== 1'b1) begin
         miscompares++; $display("FAIL press_latency: mode %0d run_en %b expected mode 2 run_en 1", mode, run_en);
      end
      cycles(1);
      vectors++;
      if (run_en !== 1'b0) begin miscompares++; $display("FAIL run_en_lag: got %b expected 0", run_en); end
      cycles(2);
      key_mode_n = 1'b1;
      cycles(10);
      vectors++;
      if (n_mode_chg !== 1 || mode !== 3'd2) begin
         miscompares++; $display("FAIL single_press: changes %0d mode %0d expected 1 change mode 2", n_mode_chg, mode);
      end
   endtask

   task automatic test_simultaneous();
      clear_obs();
      press_key(3, 10);
      vectors++;
      if (mode !== 3'd3 || n_mode_chg !== 1) begin
         miscompares++; $display("FAIL simul_mode: mode %0d changes %0d expected mode 3 changes 1", mode, n_mode_chg);
      end
      vectors++;
      if (n_hour !== 0 || n_min !== 0 || n_sec !== 0) begin
         miscompares++; $display("FAIL simul_inc_dropped: hour %0d min %0d sec %0d expected 0 0 0", n_hour, n_min, n_sec);
      end
   endtask

   task automatic test_inc_min();
      clear_obs();
      press_key(1, 8);
      press_key(1, 8);
      vectors++;
      if (n_min !== 2) begin miscompares++; $display("FAIL inc_min_count: got %0d expected 2", n_min); end
      vectors++;
      if (max_run !== 1) begin miscompares++; $display("FAIL inc_width: got %0d expected 1", max_run); end
      vectors++;
      if (first_min_idx !== 7) begin miscompares++; $display("FAIL inc_latency: got cycle %0d expected 7", first_min_idx); end
      vectors++;
      if (n_sec !== 0 || n_hour !== 0) begin
         miscompares++; $display("FAIL inc_other_fields: sec %0d hour %0d expected 0 0", n_sec, n_hour);
      end
      vectors++;
      if (blink_bad !== 0 || blink_tog < 3) begin
         miscompares++; $display("FAIL blink_period: bad %0d toggles %0d expected 0 bad, >=3 toggles", blink_bad, blink_tog);
      end
      vectors++;
      if (n_bs !== 0 || n_bh !== 0) begin
         miscompares++; $display("FAIL blank_other: sec %0d hour %0d expected 0 0", n_bs, n_bh);
      end
      vectors++;
      if (mode !== 3'd3) begin miscompares++; $display("FAIL inc_keeps_mode: mode %0d expected 3", mode); end
   endtask

   task automatic test_timeout();
      clear_obs();
      press_key(0, 8);
      vectors++;
      if (mode !== 3'd4) begin miscompares++; $display("FAIL enter_set_sec: mode %0d expected 4", mode); end
      pulse_tick(); cycles(4);
      pulse_tick(); cycles(4);
      press_key(1, 8);
      vectors++;
      if (n_sec !== 1) begin miscompares++; $display("FAIL inc_sec_count: got %0d expected 1", n_sec); end
      pulse_tick(); cycles(4);
      pulse_tick(); cycles(4);
      vectors++;
      if (mode !== 3'd4) begin miscompares++; $display("FAIL timeout_restart: mode %0d expected 4", mode); end
      pulse_tick();
      vectors++;
      if (mode !== 3'd0 || run_en !== 1'b0) begin
         miscompares++; $display("FAIL timeout_exit: mode %0d run_en %b expected mode 0 run_en 0", mode, run_en);
      end
      cyc();
      vectors++;
      if (run_en !== 1'b1) begin miscompares++; $display("FAIL timeout_run_en: got %b expected 1", run_en); end
   endtask

   task automatic test_reset_mid();
      clear_obs();
      press_key(2, 8);
      vectors++;
      if (mode !== 3'd1 || run_en !== 1'b0) begin
         miscompares++; $display("FAIL enter_pause: mode %0d run_en %b expected 1 0", mode, run_en);
      end
      press_key(1, 8);
      vectors++;
      if (n_sec !== 0 || n_min !== 0 || n_hour !== 0 || mode !== 3'd1) begin
         miscompares++; $display("FAIL pause_inc_ignored: sec %0d min %0d hour %0d mode %0d expected 0 0 0 1",
                                 n_sec, n_min, n_hour, mode);
      end
      key_run_n = 1'b0;
      cycles(3);
      rst = 1'b1;
      cyc();
      vectors++;
      if (mode !== 3'd0 || run_en !== 1'b1) begin
         miscompares++; $display("FAIL mid_reset: mode %0d run_en %b expected 0 1", mode, run_en);
      end
      cyc();
      rst = 1'b0;
      clear_obs();
      cycles(20);
      vectors++;
      if (n_mode_chg !== 0 || mode !== 3'd0) begin
         miscompares++; $display("FAIL held_through_reset: changes %0d mode %0d expected 0 0", n_mode_chg, mode);
      end
      key_run_n = 1'b1;
      cycles(10);
      press_key(2, 8);
      vectors++;
      if (mode !== 3'd1) begin miscompares++; $display("FAIL repress_after_reset: mode %0d expected 1", mode); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_simultaneous();
      test_inc_min();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Front-panel controller for the digital clock. Debounces the three push-keys and runs the mode FSM (RUN / PAUSE / SET_HOUR / SET_MIN / SET_SEC). Drives the count-enable and single-cycle increment strobes into the second, minute and hour counters, plus per-field blank signals for the HEX display drivers. Sits between the raw KEY inputs and the counter chain.

Parameters:
DEBOUNCE_CYC, 16'd50000, clk cycles a raw key must stay stable before its new level is accepted
BLINK_CYC, 24'd12500000, clk cycles per blink half-period of the selected field
TIMEOUT_S, 6'd30, tick_1hz pulses without a key press before SET_* returns to RUN

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_1hz  in  1  one-clk-wide pulse, once per second
key_mode_n  in  1  raw mode key, active-low, asynchronous
key_inc_n  in  1  raw increment key, active-low, asynchronous
key_run_n  in  1  raw run/pause key, active-low, asynchronous
run_en  out  1  counter-chain count enable
inc_sec  out  1  one-cycle strobe: seconds +1, wraps 59->0, no carry
inc_min  out  1  one-cycle strobe: minutes +1, wraps 59->0, no carry
inc_hour  out  1  one-cycle strobe: hours +1, wraps 23->0
mode  out  3  current FSM state encoding
blank_sec, blank_min, blank_hour  out  1 each  1 = blank that HEX pair

Behaviour:
- All flops use synchronous, active-high rst. Reset values: state=RUN, run_en=1, all inc_* =0, all blank_* =0, blink_phase=0, timeout count=0, debouncers at released level (1).
- Each key passes through a 2-flop synchroniser and then a stability counter. The accepted level changes only after DEBOUNCE_CYC consecutive equal samples. The key press is a one-cycle pulse on the accepted 1->0 transition. Release produces no event.
- FSM, one transition per press:
  - RUN: mode_press -> SET_HOUR; run_press -> PAUSE.
  - PAUSE: mode_press -> SET_HOUR; run_press -> RUN.
  - SET_HOUR -> SET_MIN -> SET_SEC -> RUN on each mode_press.
  - run_press is ignored in all SET_* states.
- Encoding: RUN=0, PAUSE=1, SET_HOUR=2, SET_MIN=3, SET_SEC=4. Unused codes go to RUN on the next clk.
- run_en = 1 only in RUN. Registered, so it changes on the clk after the state changes.
- inc_press in SET_HOUR/MIN/SET_SEC drives inc_hour/inc_min/inc_sec high for exactly one clk. Latency: one clk after the press pulse. inc_press in RUN or PAUSE is ignored.
- Simultaneous events: mode_press has priority. An inc_press or run_press in the same cycle is dropped. Presses are never queued.
- Timeout (SET_* only): the counter increments on tick_1hz and clears on any press or state change. When it reaches TIMEOUT_S, the FSM goes to RUN. If tick and press arrive together, the press wins and the counter clears.
- Blink: a free-running counter toggles blink_phase every BLINK_CYC clks. blank_x = blink_phase when in SET_x, else 0. blink_phase restarts at 0 on every entry to a SET state.
- Reset mid-operation, including mid-debounce or mid-strobe: all outputs return to reset values on the next clk edge. A key held through reset does not generate a press until it is released and pressed again.

Optional Feature:
CLOCK_MODE_CTRL_AUTOREPEAT_EN
- Defined: in SET_* states, if key_inc stays accepted-low for 64*DEBOUNCE_CYC clks, an extra inc strobe fires every 16*DEBOUNCE_CYC clks until the key is released. Mode change or timeout stops the repeat.
- Undefined: exactly one strobe per press, and none of the repeat logic is synthesised.

Decomposition:
- Package clock_ui_pkg: state enum and its encodings; field-select constants; the default DEBOUNCE_CYC, BLINK_CYC and TIMEOUT_S values, shared with the counter modules.
- One sub-module, key_debounce (synchroniser, stability counter, press pulse), instantiated three times.

Test Plan:
1. DEBOUNCE_CYC=4, BLINK_CYC=8: rst high for 2 clk -> run_en=1, mode=0, all strobes and blanks 0.
2. key_mode_n low for 3 clk then high -> no transition. Low for 10 clk -> mode=2 exactly once; run_en=0 one clk later.
3. In SET_MIN, two separate inc presses -> exactly two 1-clk inc_min pulses; inc_sec and inc_hour stay 0; blank_min toggles every 8 clk.
4. mode_press and inc_press debounced in the same cycle while in SET_HOUR -> mode=3, no inc_hour pulse.
5. TIMEOUT_S=3, in SET_SEC with no keys -> after the 3rd tick_1hz, mode=0 and run_en=1. A press between ticks restarts the count.
6. Assert rst while in PAUSE with key_run_n held low -> mode=0, run_en=1, and no press event until the key is released and pressed again.
